// File: rtl/serial_ripple_subtractor.sv
// Bit-serial subtractor: d = a - b - bi, one bit per clock through a single full-subtractor
// cell with a registered borrow. Valid/ready handshakes on both the operand and result sides.
module serial_ripple_subtractor #(
  parameter int unsigned DATA_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic                  bi,
  input  logic                  din_vld,
  output logic                  din_rd,
  output logic [DATA_WIDTH-1:0] d,
  output logic                  bo,
  output logic                  dout_vld,
  input  logic                  dout_rd
);

  localparam int unsigned   CntW    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e state_q, state_d;

  logic [DATA_WIDTH-1:0] sa_q, sa_d;
  logic [DATA_WIDTH-1:0] sb_q, sb_d;
  logic [DATA_WIDTH-1:0] res_q, res_d;
  logic [DATA_WIDTH-1:0] d_q, d_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  borrow_q, borrow_d;
  logic                  bo_q, bo_d;
  logic                  vld_q, vld_d;

  logic                  accept;
  logic                  bit_last;
  logic                  x, y, r;
  logic                  diff_bit;
  logic                  borrow_nxt;
  logic [DATA_WIDTH:0]   res_shift;

  // Full-subtractor cell on the current LSBs.
  assign x          = sa_q[0];
  assign y          = sb_q[0];
  assign r          = borrow_q;
  assign diff_bit   = x ^ y ^ r;
  assign borrow_nxt = (~x & y) | (~x & r) | (y & r);

  // Result enters from the MSB side; the widened concat keeps DATA_WIDTH=1 legal.
  assign res_shift  = {diff_bit, res_q};
  assign bit_last   = (cnt_q == CntLast);
  assign accept     = din_vld & din_rd;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StRun;
      StRun:   if (bit_last) state_d = StDone;
      StDone:  if (vld_q && dout_rd) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs.
  always_comb begin
    din_rd   = (state_q == StIdle) && !rst;
    d        = d_q;
    bo       = bo_q;
    dout_vld = vld_q;
  end

  // Datapath next-state.
  always_comb begin
    sa_d     = sa_q;
    sb_d     = sb_q;
    res_d    = res_q;
    borrow_d = borrow_q;
    cnt_d    = cnt_q;
    d_d      = d_q;
    bo_d     = bo_q;
    vld_d    = vld_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          sa_d     = a;
          sb_d     = b;
          borrow_d = bi;
          cnt_d    = '0;
        end
      end
      StRun: begin
        sa_d     = sa_q >> 1;
        sb_d     = sb_q >> 1;
        res_d    = res_shift[DATA_WIDTH:1];
        borrow_d = borrow_nxt;
        cnt_d    = cnt_q + 1'b1;
        if (bit_last) begin
          d_d   = res_shift[DATA_WIDTH:1];
          bo_d  = borrow_nxt;
          vld_d = 1'b1;
        end
      end
      StDone: begin
        if (dout_rd) vld_d = 1'b0;
      end
      default: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      sa_q     <= '0;
      sb_q     <= '0;
      res_q    <= '0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
      d_q      <= '0;
      bo_q     <= 1'b0;
      vld_q    <= 1'b0;
    end else begin
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      res_q    <= res_d;
      borrow_q <= borrow_d;
      cnt_q    <= cnt_d;
      d_q      <= d_d;
      bo_q     <= bo_d;
      vld_q    <= vld_d;
    end
  end

  // A stalled result must not move.
  property p_out_hold;
    @(posedge clk) disable iff (rst)
      (dout_vld && !dout_rd) |=> (dout_vld && $stable(d) && $stable(bo));
  endproperty
  assert property (p_out_hold);

  // Result valid only ever appears in StDone.
  property p_vld_done;
    @(posedge clk) disable iff (rst) dout_vld |-> (state_q == StDone);
  endproperty
  assert property (p_vld_done);

endmodule
